packet_frame_loader: RTL and testbench

PACKET_FRAME_LOADER -- requirements
Module: packet_frame_loader

---
 rtl/packet_frame_loader.sv | 148 ++++++++++++++
 tb/tb_packet_frame_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/packet_frame_loader.sv
// Collects fixed-size packets into an N_SAMPLES-deep sample buffer and hands the
// completed frame to a consumer, aborting partial frames on an inter-packet gap timeout.
module packet_frame_loader #(
  parameter logic [15:0] PACKET_SIZE = 16'd2,
  parameter int          N_SAMPLES   = 64,
  parameter int          ADDR_W      = 6,
  parameter logic [23:0] TIMEOUT     = 24'd120000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PACKET_SIZE*8-1:0] packet,
  input  logic                     packet_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [PACKET_SIZE*8-1:0] wr_data,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     overrun_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [23:0]       GAP_LAST  = TIMEOUT - 24'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                   r_state, w_stateNext;
  logic [ADDR_W-1:0]        r_count, w_countNext;
  logic [23:0]              r_gap, w_gapNext;
  logic                     r_wrEn, w_wrEnNext;
  logic [ADDR_W-1:0]        r_wrAddr, w_wrAddrNext;
  logic [PACKET_SIZE*8-1:0] r_wrData, w_wrDataNext;
  logic                     r_frameValid, w_frameValidNext;
  logic                     r_busy, w_busyNext;
  logic                     r_timeoutErr, w_timeoutErrNext;
  logic                     r_overrunErr, w_overrunErrNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_gap        <= '0;
      r_wrEn       <= 1'b0;
      r_wrAddr     <= '0;
      r_wrData     <= '0;
      r_frameValid <= 1'b0;
      r_busy       <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_overrunErr <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_count      <= w_countNext;
      r_gap        <= w_gapNext;
      r_wrEn       <= w_wrEnNext;
      r_wrAddr     <= w_wrAddrNext;
      r_wrData     <= w_wrDataNext;
      r_frameValid <= w_frameValidNext;
      r_busy       <= w_busyNext;
      r_timeoutErr <= w_timeoutErrNext;
      r_overrunErr <= w_overrunErrNext;
    end
  end

  // All outputs are registered; this block decides their values for the next cycle.
  always_comb begin
    w_stateNext      = r_state;
    w_countNext      = r_count;
    w_gapNext        = r_gap;
    w_wrEnNext       = 1'b0;
    w_wrAddrNext     = r_wrAddr;
    w_wrDataNext     = r_wrData;
    w_frameValidNext = r_frameValid;
    w_busyNext       = r_busy;
    w_timeoutErrNext = r_timeoutErr;
    w_overrunErrNext = r_overrunErr;

    unique case (r_state)
      IDLE: begin
        if (packet_ready) begin
          w_wrEnNext       = 1'b1;
          w_wrAddrNext     = '0;
          w_wrDataNext     = packet;
          w_timeoutErrNext = 1'b0;
          w_countNext      = ADDR_W'(1);
          w_gapNext        = '0;
          w_busyNext       = 1'b1;
          w_stateNext      = LOAD;
        end
      end

      LOAD: begin
        // A packet arriving on the last gap cycle still counts, so it is tested first.
        if (packet_ready) begin
          w_wrEnNext   = 1'b1;
          w_wrAddrNext = r_count;
          w_wrDataNext = packet;
          w_gapNext    = '0;
          if (r_count == LAST_ADDR) begin
            w_frameValidNext = 1'b1;
            w_busyNext       = 1'b0;
            w_countNext      = '0;
            w_stateNext      = FULL;
          end else begin
            w_countNext = r_count + 1'b1;
          end
        end else if (r_gap == GAP_LAST) begin
          w_stateNext      = IDLE;
          w_busyNext       = 1'b0;
          w_countNext      = '0;
          w_gapNext        = '0;
          w_timeoutErrNext = 1'b1;
        end else begin
          w_gapNext = r_gap + 24'd1;
        end
      end

      FULL: begin
        if (frame_ack) begin
          w_frameValidNext = 1'b0;
          w_overrunErrNext = 1'b0;
          w_stateNext      = IDLE;
        end
        // A dropped packet outranks the acknowledge's clear of the overrun flag.
        if (packet_ready) begin
          w_overrunErrNext = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign wr_en       = r_wrEn;
  assign wr_addr     = r_wrAddr;
  assign wr_data     = r_wrData;
  assign frame_valid = r_frameValid;
  assign busy        = r_busy;
  assign timeout_err = r_timeoutErr;
  assign overrun_err = r_overrunErr;

endmodule

// File: tb/tb_packet_frame_loader.sv
// Directed bench for packet_frame_loader with 4-sample frames and a 100-cycle gap timeout.
module tb_packet_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] packet;
  logic        packet_ready;
  logic        frame_ack;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_valid;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    int          idle;
    logic        ready;
    logic        ack;
    logic [15:0] pkt;
    logic        eWr;
    logic [1:0]  eAddr;
    logic [15:0] eData;
    logic        eFv;
    logic        eBusy;
    logic        eTo;
    logic        eOv;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  packet_frame_loader #(
    .PACKET_SIZE(16'd2),
    .N_SAMPLES  (4),
    .ADDR_W     (2),
    .TIMEOUT    (24'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .packet      (packet),
    .packet_ready(packet_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  // Inputs change on the falling edge and outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic a, input logic [15:0] p);
    @(negedge clk);
    packet_ready = r;
    frame_ack    = a;
    packet       = p;
    @(posedge clk);
    #1;
    packet_ready = 1'b0;
    frame_ack    = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic eWr, input logic [1:0] eAddr,
                             input logic [15:0] eData, input logic eFv, input logic eBusy,
                             input logic eTo, input logic eOv, input logic full);
    logic [22:0] act, exp, mask;
    act  = {wr_en, wr_addr, wr_data, frame_valid, busy, timeout_err, overrun_err};
    exp  = {eWr, eAddr, eData, eFv, eBusy, eTo, eOv};
    mask = (eWr || full) ? '1 : {1'b1, 18'b0, 4'hF};
    testsRun++;
    if ((act & mask) !== (exp & mask)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got wr_en=%b addr=%0d data=%h fv=%b busy=%b to=%b ov=%b, expected wr_en=%b addr=%0d data=%h fv=%b busy=%b to=%b ov=%b",
               name, wr_en, wr_addr, wr_data, frame_valid, busy, timeout_err, overrun_err,
               eWr, eAddr, eData, eFv, eBusy, eTo, eOv);
    end
  endtask

  task automatic addVec(input int idle, input logic r, input logic a, input logic [15:0] p,
                        input logic eWr, input logic [1:0] eAddr, input logic [15:0] eData,
                        input logic eFv, input logic eBusy, input logic eTo, input logic eOv);
    vec_t v;
    v.idle = idle; v.ready = r; v.ack = a; v.pkt = p;
    v.eWr = eWr; v.eAddr = eAddr; v.eData = eData;
    v.eFv = eFv; v.eBusy = eBusy; v.eTo = eTo; v.eOv = eOv;
    vecs.push_back(v);
  endtask

  initial begin
    rst          = 1'b1;
    packet       = 16'h0000;
    packet_ready = 1'b0;
    frame_ack    = 1'b0;

    // Frame of 4 packets 20 cycles apart, then overrun handling, then ack+packet collision.
    addVec(0,  1, 0, 16'h1111, 1, 0, 16'h1111, 0, 1, 0, 0);
    addVec(0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0);
    addVec(18, 1, 0, 16'h2222, 1, 1, 16'h2222, 0, 1, 0, 0);
    addVec(0,  0, 1, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0);
    addVec(18, 1, 0, 16'h3333, 1, 2, 16'h3333, 0, 1, 0, 0);
    addVec(19, 1, 0, 16'h4444, 1, 3, 16'h4444, 1, 0, 0, 0);
    addVec(0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);
    addVec(5,  1, 0, 16'hAAAA, 0, 0, 16'h0000, 1, 0, 0, 1);
    addVec(0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1);
    addVec(3,  0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    addVec(0,  0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    addVec(0,  1, 0, 16'h5555, 1, 0, 16'h5555, 0, 1, 0, 0);
    addVec(1,  1, 0, 16'h6666, 1, 1, 16'h6666, 0, 1, 0, 0);
    addVec(0,  1, 0, 16'h7777, 1, 2, 16'h7777, 0, 1, 0, 0);
    addVec(2,  1, 0, 16'h8888, 1, 3, 16'h8888, 1, 0, 0, 0);
    addVec(1,  1, 1, 16'hBBBB, 0, 0, 16'h0000, 0, 0, 0, 1);
    addVec(0,  1, 0, 16'hCCCC, 1, 0, 16'hCCCC, 0, 1, 0, 1);
    addVec(0,  1, 0, 16'hDDDD, 1, 1, 16'hDDDD, 0, 1, 0, 1);
    addVec(0,  1, 0, 16'hEEEE, 1, 2, 16'hEEEE, 0, 1, 0, 1);
    addVec(0,  1, 0, 16'hFFFF, 1, 3, 16'hFFFF, 1, 0, 0, 1);
    addVec(0,  0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);

    #2;
    checkOutput("reset_state", 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].idle) applyStimulus(0, 0, 16'h0000);
      applyStimulus(vecs[i].ready, vecs[i].ack, vecs[i].pkt);
      checkOutput($sformatf("vec%0d", i), vecs[i].eWr, vecs[i].eAddr, vecs[i].eData,
                  vecs[i].eFv, vecs[i].eBusy, vecs[i].eTo, vecs[i].eOv, 0);
    end

    // Gap timeout: two packets then 100 idle cycles abort the frame.
    applyStimulus(1, 0, 16'h0101);
    checkOutput("to_first", 1, 0, 16'h0101, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h0202);
    checkOutput("to_second", 1, 1, 16'h0202, 0, 1, 0, 0, 0);
    repeat (99) applyStimulus(0, 0, 16'h0000);
    checkOutput("to_gap99", 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000);
    checkOutput("to_expired", 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 16'h0000);
    checkOutput("to_persist", 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 16'h0303);
    checkOutput("to_restart0", 1, 0, 16'h0303, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h0404);
    checkOutput("to_restart1", 1, 1, 16'h0404, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h0505);
    checkOutput("to_restart2", 1, 2, 16'h0505, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h0606);
    checkOutput("to_restart3", 1, 3, 16'h0606, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0000);
    checkOutput("to_ack", 0, 0, 16'h0000, 0, 0, 0, 0, 0);

    // Packet on the very last gap cycle is accepted instead of timing out.
    applyStimulus(1, 0, 16'h1212);
    checkOutput("edge_first", 1, 0, 16'h1212, 0, 1, 0, 0, 0);
    repeat (99) applyStimulus(0, 0, 16'h0000);
    applyStimulus(1, 0, 16'h3434);
    checkOutput("edge_late", 1, 1, 16'h3434, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000);
    checkOutput("edge_after", 0, 0, 16'h0000, 0, 1, 0, 0, 0);

    // Asynchronous reset discards the partial frame.
    applyStimulus(1, 0, 16'h5656);
    checkOutput("rst_partial", 1, 2, 16'h5656, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 16'h9001);
    checkOutput("rst_new0", 1, 0, 16'h9001, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h9002);
    checkOutput("rst_new1", 1, 1, 16'h9002, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h9003);
    checkOutput("rst_new2", 1, 2, 16'h9003, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 16'h9004);
    checkOutput("rst_new3", 1, 3, 16'h9004, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
